// File: rtl/apb_master_bridge.sv
// apb_master_bridge: single processor request port fanned out to NUM_SLV APB slaves by address decode.
// Latency: zero-wait transfer gives done 3 cycles after req is sampled; decode error gives done the next cycle.
// Backpressure: selected PReady stretches ACCESS up to TIMEOUT cycles, then aborts; req is ignored while busy.
module apb_master_bridge #(
    parameter int ADDR_W  = 16,
    parameter int DATA_W  = 8,
    parameter int NUM_SLV = 2,
    parameter int TIMEOUT = 15
) (
    input  logic                      sysclk,
    input  logic                      reset,
    input  logic                      req,
    input  logic [ADDR_W-1:0]         address,
    input  logic [DATA_W-1:0]         writeData,
    input  logic                      we,
    output logic [DATA_W-1:0]         readData,
    output logic                      done,
    output logic                      err,
    output logic                      busy,
    output logic [ADDR_W-1:0]         PAddr,
    output logic [NUM_SLV-1:0]        PSelx,
    output logic                      PEnable,
    output logic                      PWrite,
    output logic [DATA_W-1:0]         PWData,
    input  logic [NUM_SLV*DATA_W-1:0] PRData,
    input  logic [NUM_SLV-1:0]        PReady,
    input  logic [NUM_SLV-1:0]        PSlvErr
);

    localparam int SEL_W = (NUM_SLV > 1) ? $clog2(NUM_SLV) : 1;
    localparam int CNT_W = $clog2(TIMEOUT + 1);

    // Slave count widened by one bit so indices beyond a non-power-of-two count compare correctly.
    localparam logic [SEL_W:0]   NUM_SLV_L = (SEL_W + 1)'(NUM_SLV);
    localparam logic [CNT_W-1:0] WAIT_LAST = CNT_W'(TIMEOUT - 1);

    localparam logic [1:0] ST_IDLE   = 2'd0;
    localparam logic [1:0] ST_SETUP  = 2'd1;
    localparam logic [1:0] ST_ACCESS = 2'd2;

    logic [1:0]         state_q,   state_d;
    logic [ADDR_W-1:0]  paddr_q,   paddr_d;
    logic [DATA_W-1:0]  pwdata_q,  pwdata_d;
    logic               pwrite_q,  pwrite_d;
    logic [NUM_SLV-1:0] psel_q,    psel_d;
    logic               penable_q, penable_d;
    logic [DATA_W-1:0]  rdata_q,   rdata_d;
    logic               done_q,    done_d;
    logic               err_q,     err_d;
    logic               busy_q,    busy_d;
    logic [CNT_W-1:0]   wait_q,    wait_d;

    logic [SEL_W-1:0]   slv_idx;
    logic               slv_ok;
    logic [NUM_SLV-1:0] slv_onehot;
    logic               sel_rdy;
    logic               sel_err;
    logic [DATA_W-1:0]  lane_dat;

    // Top address bits pick the slave; out-of-range indices become a decode error.
    assign slv_idx    = address[ADDR_W-1 -: SEL_W];
    assign slv_ok     = ({1'b0, slv_idx} < NUM_SLV_L);
    assign slv_onehot = NUM_SLV'(1) << slv_idx;

    // Only the selected slave's handshake counts; PSelx is one-hot so a mask suffices.
    assign sel_rdy = |(PReady & psel_q);
    assign sel_err = |(PSlvErr & psel_q);

    // AND-OR read-data mux keyed by the registered one-hot select.
    always_comb begin
        lane_dat = '0;
        for (int i = 0; i < NUM_SLV; i++) begin
            if (psel_q[i]) begin
                lane_dat = lane_dat | PRData[i*DATA_W +: DATA_W];
            end
        end
    end

    // Next-state logic for the IDLE -> SETUP -> ACCESS transfer sequence.
    always_comb begin
        state_d   = state_q;
        paddr_d   = paddr_q;
        pwdata_d  = pwdata_q;
        pwrite_d  = pwrite_q;
        psel_d    = psel_q;
        penable_d = penable_q;
        rdata_d   = rdata_q;
        busy_d    = busy_q;
        wait_d    = wait_q;
        done_d    = 1'b0;
        err_d     = 1'b0;

        case (state_q)
            ST_IDLE: begin
                if (req) begin
                    paddr_d  = address;
                    pwdata_d = writeData;
                    pwrite_d = we;
                    if (slv_ok) begin
                        state_d   = ST_SETUP;
                        psel_d    = slv_onehot;
                        penable_d = 1'b0;
                        busy_d    = 1'b1;
                        wait_d    = '0;
                    end else begin
                        // Nothing goes on the bus; report the failure straight away.
                        done_d = 1'b1;
                        err_d  = 1'b1;
                        busy_d = 1'b0;
                    end
                end
            end
            ST_SETUP: begin
                state_d   = ST_ACCESS;
                penable_d = 1'b1;
            end
            ST_ACCESS: begin
                if (sel_rdy) begin
                    state_d   = ST_IDLE;
                    psel_d    = '0;
                    penable_d = 1'b0;
                    busy_d    = 1'b0;
                    done_d    = 1'b1;
                    err_d     = sel_err;
                    // Read data is kept even on a slave error so software can inspect it.
                    if (!pwrite_q) begin
                        rdata_d = lane_dat;
                    end
                end else if (wait_q == WAIT_LAST) begin
                    state_d   = ST_IDLE;
                    psel_d    = '0;
                    penable_d = 1'b0;
                    busy_d    = 1'b0;
                    done_d    = 1'b1;
                    err_d     = 1'b1;
                    if (!pwrite_q) begin
                        rdata_d = '0;
                    end
                end else begin
                    wait_d = wait_q + CNT_W'(1);
                end
            end
            default: begin
                state_d   = ST_IDLE;
                psel_d    = '0;
                penable_d = 1'b0;
                busy_d    = 1'b0;
            end
        endcase
    end

    // State and output registers with synchronous reset; a reset mid-transfer drops the result.
    always_ff @(posedge sysclk) begin
        if (reset) begin
            state_q   <= ST_IDLE;
            paddr_q   <= '0;
            pwdata_q  <= '0;
            pwrite_q  <= 1'b0;
            psel_q    <= '0;
            penable_q <= 1'b0;
            rdata_q   <= '0;
            done_q    <= 1'b0;
            err_q     <= 1'b0;
            busy_q    <= 1'b0;
            wait_q    <= '0;
        end else begin
            state_q   <= state_d;
            paddr_q   <= paddr_d;
            pwdata_q  <= pwdata_d;
            pwrite_q  <= pwrite_d;
            psel_q    <= psel_d;
            penable_q <= penable_d;
            rdata_q   <= rdata_d;
            done_q    <= done_d;
            err_q     <= err_d;
            busy_q    <= busy_d;
            wait_q    <= wait_d;
        end
    end

    assign readData = rdata_q;
    assign done     = done_q;
    assign err      = err_q;
    assign busy     = busy_q;
    assign PAddr    = paddr_q;
    assign PSelx    = psel_q;
    assign PEnable  = penable_q;
    assign PWrite   = pwrite_q;
    assign PWData   = pwdata_q;

endmodule

// File: tb/tb_apb_master_bridge.sv
// Testbench for apb_master_bridge: two instances (2 slaves / timeout 15, 3 slaves / timeout 4).
// A transaction-level model is stepped every cycle and compared on the falling edge.
// Directed transfers additionally pin done cycle, err and readData to hand-computed values.
module tb_apb_master_bridge;

    logic clk = 1'b0;
    logic rst;
    always #5 clk = ~clk;

    // Index 0 -> instance with 2 slaves, index 1 -> instance with 3 slaves.
    logic        req_s     [2];
    logic [15:0] addr_s    [2];
    logic [7:0]  wdata_s   [2];
    logic        we_s      [2];
    logic [23:0] prdata_s  [2];
    logic [2:0]  pready_s  [2];
    logic [2:0]  pslverr_s [2];

    logic [7:0]  rdata_w   [2];
    logic        done_w    [2];
    logic        err_w     [2];
    logic        busy_w    [2];
    logic [15:0] paddr_w   [2];
    logic        pen_w     [2];
    logic        pwrite_w  [2];
    logic [7:0]  pwdata_w  [2];
    logic [1:0]  a_psel;
    logic [2:0]  b_psel;
    logic [2:0]  psel_w    [2];

    assign psel_w[0] = {1'b0, a_psel};
    assign psel_w[1] = b_psel;

    apb_master_bridge #(.ADDR_W(16), .DATA_W(8), .NUM_SLV(2), .TIMEOUT(15)) u_a (
        .sysclk(clk), .reset(rst), .req(req_s[0]), .address(addr_s[0]),
        .writeData(wdata_s[0]), .we(we_s[0]), .readData(rdata_w[0]), .done(done_w[0]),
        .err(err_w[0]), .busy(busy_w[0]), .PAddr(paddr_w[0]), .PSelx(a_psel),
        .PEnable(pen_w[0]), .PWrite(pwrite_w[0]), .PWData(pwdata_w[0]),
        .PRData(prdata_s[0][15:0]), .PReady(pready_s[0][1:0]), .PSlvErr(pslverr_s[0][1:0])
    );

    apb_master_bridge #(.ADDR_W(16), .DATA_W(8), .NUM_SLV(3), .TIMEOUT(4)) u_b (
        .sysclk(clk), .reset(rst), .req(req_s[1]), .address(addr_s[1]),
        .writeData(wdata_s[1]), .we(we_s[1]), .readData(rdata_w[1]), .done(done_w[1]),
        .err(err_w[1]), .busy(busy_w[1]), .PAddr(paddr_w[1]), .PSelx(b_psel),
        .PEnable(pen_w[1]), .PWrite(pwrite_w[1]), .PWData(pwdata_w[1]),
        .PRData(prdata_s[1]), .PReady(pready_s[1]), .PSlvErr(pslverr_s[1])
    );

    int total = 0;
    int bad   = 0;

    task automatic check(input string nm, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s got=%0h want=%0h", nm, act, exp);
        end
    endtask

    // Transaction model: age counts cycles since acceptance (0 = no transfer in flight).
    typedef struct packed {
        int          age;
        int          waits;
        int          idx;
        logic [15:0] paddr;
        logic [7:0]  pwdata;
        logic [7:0]  rdata;
        logic        pwrite;
        logic        pen;
        logic [2:0]  psel;
        logic        done;
        logic        err;
        logic        busy;
    } mdl_t;

    mdl_t m [2];

    function automatic mdl_t step(input mdl_t cur, input int nslv, input int tmo,
                                  input logic r, input logic rq, input logic [15:0] ad,
                                  input logic [7:0] wd, input logic w, input logic [23:0] prd,
                                  input logic [2:0] rdy, input logic [2:0] serr);
        mdl_t n;
        int   sw;
        int   ix;
        logic fin;
        logic fin_err;
        logic [7:0] fin_dat;
        n       = cur;
        n.done  = 1'b0;
        n.err   = 1'b0;
        fin     = 1'b0;
        fin_err = 1'b0;
        fin_dat = 8'h00;
        if (r) begin
            n = '{default: 0};
            return n;
        end
        sw = (nslv > 1) ? $clog2(nslv) : 1;
        if (cur.age == 0) begin
            if (rq) begin
                n.paddr  = ad;
                n.pwdata = wd;
                n.pwrite = w;
                ix = int'(ad >> (16 - sw));
                if (ix < nslv) begin
                    n.age   = 1;
                    n.idx   = ix;
                    n.psel  = 3'(1 << ix);
                    n.busy  = 1'b1;
                    n.waits = 0;
                end else begin
                    n.done = 1'b1;
                    n.err  = 1'b1;
                end
            end
        end else if (cur.age == 1) begin
            n.age = 2;
            n.pen = 1'b1;
        end else begin
            if (rdy[cur.idx]) begin
                fin     = 1'b1;
                fin_err = serr[cur.idx];
                fin_dat = prd[cur.idx*8 +: 8];
            end else if (cur.waits + 1 >= tmo) begin
                fin     = 1'b1;
                fin_err = 1'b1;
                fin_dat = 8'h00;
            end else begin
                n.waits = cur.waits + 1;
            end
        end
        if (fin) begin
            n.age  = 0;
            n.psel = 3'b000;
            n.pen  = 1'b0;
            n.busy = 1'b0;
            n.done = 1'b1;
            n.err  = fin_err;
            if (!cur.pwrite) n.rdata = fin_dat;
        end
        return n;
    endfunction

    // Model steps on the rising edge from the inputs the DUT samples; outputs compared on the falling edge.
    initial begin
        forever begin
            @(posedge clk);
            for (int i = 0; i < 2; i++) begin
                m[i] = step(m[i], (i == 0) ? 2 : 3, (i == 0) ? 15 : 4, rst, req_s[i], addr_s[i],
                            wdata_s[i], we_s[i], prdata_s[i], pready_s[i], pslverr_s[i]);
            end
            @(negedge clk);
            for (int i = 0; i < 2; i++) begin
                check($sformatf("u%0d_psel", i),    32'(psel_w[i]),   32'(m[i].psel));
                check($sformatf("u%0d_penable", i), 32'(pen_w[i]),    32'(m[i].pen));
                check($sformatf("u%0d_pwrite", i),  32'(pwrite_w[i]), 32'(m[i].pwrite));
                check($sformatf("u%0d_paddr", i),   32'(paddr_w[i]),  32'(m[i].paddr));
                check($sformatf("u%0d_pwdata", i),  32'(pwdata_w[i]), 32'(m[i].pwdata));
                check($sformatf("u%0d_rdata", i),   32'(rdata_w[i]),  32'(m[i].rdata));
                check($sformatf("u%0d_done", i),    32'(done_w[i]),   32'(m[i].done));
                check($sformatf("u%0d_err", i),     32'(err_w[i]),    32'(m[i].err));
                check($sformatf("u%0d_busy", i),    32'(busy_w[i]),   32'(m[i].busy));
            end
        end
    end

    // One transfer, called at a falling edge. s is the hand-decoded slave index; the selected
    // slave holds PReady low for low_n ACCESS cycles. Unselected slaves assert ready/error to
    // prove they are ignored. Returns the cycle (counted from acceptance) on which done appeared.
    task automatic run(input int inst, input logic [15:0] ad, input logic [7:0] wd, input logic w,
                       input int s, input int low_n, input logic [7:0] rd, input logic se,
                       input logic hold, input logic [2:0] xpsel, input string nm,
                       output int dcyc, output logic derr, output logic [7:0] drd);
        req_s[inst]     = 1'b1;
        addr_s[inst]    = ad;
        wdata_s[inst]   = wd;
        we_s[inst]      = w;
        prdata_s[inst]  = {3{~rd}};
        if (s < 3) prdata_s[inst][s*8 +: 8] = rd;
        pready_s[inst]  = ~(3'b001 << s);
        pslverr_s[inst] = ~(3'b001 << s);
        if (se && s < 3) pslverr_s[inst][s] = 1'b1;
        dcyc = -1;
        derr = 1'b0;
        drd  = 8'h00;
        for (int c = 1; c <= 40 && dcyc < 0; c++) begin
            @(negedge clk);
            if (c == 1) check({nm, "_setup_psel"}, 32'(psel_w[inst]), 32'(xpsel));
            if ((c == 1 && !hold) || c == 2) req_s[inst] = 1'b0;
            if (done_w[inst]) begin
                dcyc = c;
                derr = err_w[inst];
                drd  = rdata_w[inst];
            end
            if (c >= 2 + low_n && s < 3) pready_s[inst][s] = 1'b1;
        end
        req_s[inst]     = 1'b0;
        pready_s[inst]  = 3'b000;
        pslverr_s[inst] = 3'b000;
    endtask

    int         dc;
    logic       de;
    logic [7:0] dr;
    logic [7:0] dmask;

    initial begin
        rst = 1'b1;
        for (int i = 0; i < 2; i++) begin
            req_s[i] = 1'b0; addr_s[i] = 16'h0; wdata_s[i] = 8'h0; we_s[i] = 1'b0;
            prdata_s[i] = 24'h0; pready_s[i] = 3'b0; pslverr_s[i] = 3'b0;
        end
        repeat (2) @(negedge clk);
        check("rst_done",  32'(done_w[0]), 32'd0);
        check("rst_busy",  32'(busy_w[1]), 32'd0);
        check("rst_psel",  32'(a_psel),    32'd0);
        check("rst_paddr", 32'(paddr_w[0]), 32'd0);
        rst = 1'b0;

        // 2-slave instance: write to slave 1, zero wait.
        run(0, 16'h8012, 8'hA5, 1'b1, 1, 0, 8'h00, 1'b0, 1'b0, 3'b010, "wr8012", dc, de, dr);
        check("wr8012_cyc", 32'(dc), 32'd3);
        check("wr8012_err", 32'(de), 32'd0);
        // Read slave 0 with three wait states.
        run(0, 16'h0034, 8'h00, 1'b0, 0, 3, 8'h5C, 1'b0, 1'b0, 3'b001, "rd0034", dc, de, dr);
        check("rd0034_cyc", 32'(dc), 32'd6);
        check("rd0034_rd",  32'(dr), 32'h5C);
        check("rd0034_err", 32'(de), 32'd0);
        // Slave error on a read still returns data.
        run(0, 16'h8001, 8'h00, 1'b0, 1, 0, 8'h77, 1'b1, 1'b0, 3'b010, "rdserr", dc, de, dr);
        check("rdserr_cyc", 32'(dc), 32'd3);
        check("rdserr_err", 32'(de), 32'd1);
        check("rdserr_rd",  32'(dr), 32'h77);
        // Write with req held during busy: held req is ignored, readData untouched.
        run(0, 16'h0055, 8'h3C, 1'b1, 0, 1, 8'h00, 1'b0, 1'b1, 3'b001, "wrhold", dc, de, dr);
        check("wrhold_cyc", 32'(dc), 32'd4);
        check("wrhold_rd",  32'(dr), 32'h77);
        // Read that never completes: abort after 15 low ACCESS cycles.
        run(0, 16'h0100, 8'h00, 1'b0, 0, 100, 8'hEE, 1'b0, 1'b0, 3'b001, "tmo15", dc, de, dr);
        check("tmo15_cyc", 32'(dc), 32'd17);
        check("tmo15_err", 32'(de), 32'd1);
        check("tmo15_rd",  32'(dr), 32'h00);

        // 3-slave instance: seed readData, then decode error on index 3.
        run(1, 16'h4010, 8'h00, 1'b0, 1, 0, 8'h9E, 1'b0, 1'b0, 3'b010, "rd4010", dc, de, dr);
        check("rd4010_rd", 32'(dr), 32'h9E);
        run(1, 16'hC000, 8'h00, 1'b0, 3, 0, 8'h11, 1'b0, 1'b0, 3'b000, "dec", dc, de, dr);
        check("dec_cyc", 32'(dc), 32'd1);
        check("dec_err", 32'(de), 32'd1);
        check("dec_rd",  32'(dr), 32'h9E);
        // Timeout of 4: never ready.
        run(1, 16'h0000, 8'h00, 1'b0, 0, 100, 8'h66, 1'b0, 1'b0, 3'b001, "tmo4", dc, de, dr);
        check("tmo4_cyc", 32'(dc), 32'd6);
        check("tmo4_err", 32'(de), 32'd1);
        check("tmo4_rd",  32'(dr), 32'h00);
        // TIMEOUT-1 wait states still complete normally on slave 2.
        run(1, 16'h8000, 8'h00, 1'b0, 2, 3, 8'h42, 1'b0, 1'b0, 3'b100, "edge3", dc, de, dr);
        check("edge3_cyc", 32'(dc), 32'd6);
        check("edge3_err", 32'(de), 32'd0);
        check("edge3_rd",  32'(dr), 32'h42);

        // Reset during ACCESS on the 2-slave instance, then two back-to-back writes.
        req_s[0] = 1'b1; addr_s[0] = 16'h0000; we_s[0] = 1'b0; pready_s[0] = 3'b000;
        @(negedge clk);
        req_s[0] = 1'b0;
        @(negedge clk);
        rst = 1'b1;
        @(negedge clk);
        check("rstmid_psel", 32'(a_psel),     32'd0);
        check("rstmid_pen",  32'(pen_w[0]),   32'd0);
        check("rstmid_busy", 32'(busy_w[0]),  32'd0);
        check("rstmid_done", 32'(done_w[0]),  32'd0);
        rst = 1'b0;
        req_s[0] = 1'b1; addr_s[0] = 16'h8004; wdata_s[0] = 8'h11; we_s[0] = 1'b1;
        pready_s[0] = 3'b010;
        dmask = 8'h00;
        for (int c = 1; c <= 7; c++) begin
            @(negedge clk);
            if (c == 1 || c == 4) req_s[0] = 1'b0;
            if (done_w[0]) dmask[c] = 1'b1;
            if (c == 3) begin
                req_s[0] = 1'b1; addr_s[0] = 16'h0006; wdata_s[0] = 8'h22; we_s[0] = 1'b1;
                pready_s[0] = 3'b011;
            end
        end
        check("b2b_done_cycles", 32'(dmask), 32'h48);
        pready_s[0] = 3'b000;

        repeat (3) @(negedge clk);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
